// File: rtl/ks_prefix_sum_pipe8b.sv
// Three-stage Kogge-Stone prefix network (spans 1, 2, 4) with sum/carry-out and valid/ready flow control.
// Optional signed-overflow output enabled by defining KS_OVF_FLAG_EN.
module ks_prefix_sum_pipe8b (
    input  logic       clk,
    input  logic       rst,
    input  logic       inValid,
    output logic       inReady,
    input  logic [7:0] P,
    input  logic [7:0] G,
    input  logic       inCin,
    output logic       outValid,
    input  logic       outReady,
    output logic [7:0] outSum,
    output logic       outCout
`ifdef KS_OVF_FLAG_EN
    ,
    output logic       outOvf
`endif
);

    // Handshake: a beat moves on inValid & inReady at the input and on outValid & outReady
    // at the output; the whole pipe advances together whenever the output slot is free or draining.
    logic en;
    assign en      = !outValid | outReady;
    assign inReady = en;

    // Bits below the span pass through; the shifted operand is zero there.
    function automatic logic [7:0] ksGen(input logic [7:0] g, input logic [7:0] p, input int d);
        return g | (p & (g << d));
    endfunction

    function automatic logic [7:0] ksProp(input logic [7:0] p, input int d);
        logic [7:0] lowMask;
        lowMask = (8'd1 << d) - 8'd1;
        return p & ((p << d) | lowMask);
    endfunction

    // Carry-in folded into bit 0 so the prefix G directly gives the carry into each bit.
    logic [7:0] foldG;
    assign foldG = {G[7:1], G[0] | (P[0] & inCin)};

    logic       s1Valid, s2Valid;
    logic [7:0] s1G, s1P, s1Porig;
    logic [7:0] s2G, s2P, s2Porig;
    logic       s1Cin, s2Cin;

    logic [7:0] gPrefix;
    logic [7:0] carry;
    logic [7:0] sumNext;
    assign gPrefix = ksGen(s2G, s2P, 4);
    assign carry   = {gPrefix[6:0], s2Cin};
    assign sumNext = s2Porig ^ carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid  <= 1'b0;
            s2Valid  <= 1'b0;
            outValid <= 1'b0;
            outSum   <= 8'h00;
            outCout  <= 1'b0;
        end else if (en) begin
            s1Valid  <= inValid;
            s2Valid  <= s1Valid;
            outValid <= s2Valid;
            outSum   <= sumNext;
            outCout  <= gPrefix[7];
        end
    end

    // Intermediate stage data is don't-care behind a cleared valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            s1G     <= ksGen(foldG, P, 1);
            s1P     <= ksProp(P, 1);
            s1Porig <= P;
            s1Cin   <= inCin;
            s2G     <= ksGen(s1G, s1P, 2);
            s2P     <= ksProp(s1P, 2);
            s2Porig <= s1Porig;
            s2Cin   <= s1Cin;
        end
    end

`ifdef KS_OVF_FLAG_EN
    // Overflow is carry into the sign bit xor carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            outOvf <= 1'b0;
        end else if (en) begin
            outOvf <= gPrefix[6] ^ gPrefix[7];
        end
    end
`endif

endmodule

// File: tb/tb_ks_prefix_sum_pipe8b.sv
// Self-checking bench for ks_prefix_sum_pipe8b: directed vectors, bubbles, backpressure,
// random streaming and mid-flight reset, with an arithmetic reference model feeding a scoreboard.
module tb_ks_prefix_sum_pipe8b;

  logic       clk = 1'b0;
  logic       rst;
  logic       inValid;
  logic       inReady;
  logic [7:0] P;
  logic [7:0] G;
  logic       inCin;
  logic       outValid;
  logic       outReady;
  logic [7:0] outSum;
  logic       outCout;
  logic       gotOvf;

  int checks  = 0;
  int errors  = 0;
  int rxCount = 0;
  logic [9:0] exp_q[$];

`ifdef KS_OVF_FLAG_EN
  localparam int CW = 10;
  logic outOvf;
  assign gotOvf = outOvf;
`else
  localparam int CW = 9;
  assign gotOvf = 1'b0;
`endif

  ks_prefix_sum_pipe8b dut (
    .clk      (clk),
    .rst      (rst),
    .inValid  (inValid),
    .inReady  (inReady),
    .P        (P),
    .G        (G),
    .inCin    (inCin),
    .outValid (outValid),
    .outReady (outReady),
    .outSum   (outSum),
    .outCout  (outCout)
`ifdef KS_OVF_FLAG_EN
    ,
    .outOvf   (outOvf)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference: A+B = P + 2G when P = A^B and G = A&B; overflow = carry into bit 7 xor carry out.
  function automatic logic [9:0] model(input logic [7:0] p, input logic [7:0] g, input logic c);
    logic [8:0] full;
    logic [7:0] low;
    full = {1'b0, p} + {g, 1'b0} + {8'd0, c};
    low  = {1'b0, p[6:0]} + {g[6:0], 1'b0} + {7'd0, c};
    return {low[7] ^ full[8], full};
  endfunction

  // driver tasks
  task automatic set_ab(input logic [7:0] a, input logic [7:0] b, input logic c);
    P     = a ^ b;
    G     = a & b;
    inCin = c;
  endtask

  task automatic set_random;
    set_ab(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  // scoreboard: push on accept, pop and compare on consume, flush on reset
  always @(negedge clk) begin
    logic [9:0] exp;
    logic [9:0] got;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (outValid && outReady) begin
        checks++;
        got = {gotOvf, outCout, outSum};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_beat got=%h expected none", got);
        end else begin
          exp = exp_q.pop_front();
          rxCount++;
          if (got[CW-1:0] !== exp[CW-1:0]) begin
            errors++;
            $display("FAIL sb_data got=%h expected=%h", got[CW-1:0], exp[CW-1:0]);
          end
        end
      end
      if (inValid && inReady) exp_q.push_back(model(P, G, inCin));
    end
  end

  task automatic test_reset;
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got=%b expected=0", outValid); end
    checks++; if (outSum !== 8'h00) begin errors++; $display("FAIL reset_outSum got=%h expected=00", outSum); end
    checks++; if (outCout !== 1'b0) begin errors++; $display("FAIL reset_outCout got=%b expected=0", outCout); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got=%b expected=1", inReady); end
`ifdef KS_OVF_FLAG_EN
    checks++; if (outOvf !== 1'b0) begin errors++; $display("FAIL reset_outOvf got=%b expected=0", outOvf); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [7:0] tp[4]   = '{8'h66, 8'hFE, 8'hFF, 8'h7E};
    logic [7:0] tg[4]   = '{8'h18, 8'h01, 8'h00, 8'h01};
    logic       tc[4]   = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] eSum[4] = '{8'h96, 8'h00, 8'h00, 8'h80};
    logic       eCo[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       eOv[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      P = tp[i]; G = tg[i]; inCin = tc[i]; inValid = 1'b1;
      @(negedge clk);
      checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL dir%0d_inReady got=%b expected=1", i, inReady); end
      @(posedge clk); #1;
      inValid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got=%b expected=0", i, outValid); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL dir%0d_outValid got=%b expected=1", i, outValid); end
      checks++; if (outSum !== eSum[i]) begin errors++; $display("FAIL dir%0d_outSum got=%h expected=%h", i, outSum, eSum[i]); end
      checks++; if (outCout !== eCo[i]) begin errors++; $display("FAIL dir%0d_outCout got=%b expected=%b", i, outCout, eCo[i]); end
`ifdef KS_OVF_FLAG_EN
      checks++; if (outOvf !== eOv[i]) begin errors++; $display("FAIL dir%0d_outOvf got=%b expected=%b", i, outOvf, eOv[i]); end
`else
      if (eOv[i] === 1'bx) $display("unreachable");
`endif
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bubbles;
    logic pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    outReady = 1'b1;
    for (int t = 0; t < 8; t++) begin
      inValid = (t < 5) ? pat[t] : 1'b0;
      set_random();
      @(negedge clk);
      if (t >= 3) begin
        checks++;
        if (outValid !== pat[t-3]) begin
          errors++; $display("FAIL bubble_t%0d_outValid got=%b expected=%b", t, outValid, pat[t-3]);
        end
      end
      @(posedge clk); #1;
    end
    inValid = 1'b0;
  endtask

  task automatic test_backpressure;
    int   sent = 0;
    int   rx0 = rxCount;
    int   stallLeft = 4;
    bit   have = 0;
    bit   seenValid = 0;
    bit   heldSet = 0;
    bit   acc;
    logic [8:0] held;
    outReady = 1'b1;
    for (int s = 0; s < 60 && (rxCount - rx0) < 5; s++) begin
      if (outValid && !seenValid) seenValid = 1;
      outReady = (seenValid && stallLeft > 0) ? 1'b0 : 1'b1;
      if (!have && sent < 5) begin set_random(); inValid = 1'b1; have = 1; end
      @(negedge clk);
      if (!outReady) begin
        checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL bp_inReady got=%b expected=0", inReady); end
        checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL bp_outValid got=%b expected=1", outValid); end
        if (heldSet) begin
          checks++;
          if ({outCout, outSum} !== held) begin
            errors++; $display("FAIL bp_stable got=%h expected=%h", {outCout, outSum}, held);
          end
        end else begin
          held = {outCout, outSum}; heldSet = 1;
        end
        stallLeft--;
      end
      acc = inValid && inReady;
      @(posedge clk); #1;
      if (acc) begin have = 0; sent++; inValid = 1'b0; end
    end
    checks++;
    if ((rxCount - rx0) != 5) begin errors++; $display("FAIL bp_delivered got=%0d expected=5", rxCount - rx0); end
    outReady = 1'b1;
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int rx0 = rxCount;
    bit have = 0;
    bit acc;
    for (int s = 0; s < 600 && (rxCount - rx0) < 40; s++) begin
      if (!have && sent < 40 && $urandom_range(0, 3) != 0) begin
        set_random(); inValid = 1'b1; have = 1;
      end
      outReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = inValid && inReady;
      @(posedge clk); #1;
      if (acc) begin have = 0; sent++; inValid = 1'b0; end
    end
    checks++;
    if ((rxCount - rx0) != 40) begin errors++; $display("FAIL b2b_delivered got=%0d expected=40", rxCount - rx0); end
    outReady = 1'b1;
  endtask

  task automatic test_reset_midflight;
    outReady = 1'b1;
    set_random(); inValid = 1'b1;
    @(posedge clk); #1;
    set_random();
    @(posedge clk); #1;
    inValid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL midrst_outValid got=%b expected=0", outValid); end
    checks++; if (outSum !== 8'h00) begin errors++; $display("FAIL midrst_outSum got=%h expected=00", outSum); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL midrst_stale_c%0d got=%b expected=0", i, outValid); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; P = 8'h00; G = 8'h00; inCin = 1'b0; outReady = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_directed();
    test_bubbles();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d expected=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
